complex_accumulator: RTL and testbench

- Streaming complex accumulator directly downstream of the fixed-point complex multiplier.
- Sums a frame of complex products (y_Re, y_Im) into one complex result. This forms one convolution/correlation output tap.
- Carries the multiplier's per-product error (overflow | bad_rep) into a per-frame sticky flag.
- Valid/ready handshake on input and output; same QI.QF signed fixed-point format in and out.

---
 rtl/complex_accumulator.sv | 148 ++++++++++++++
 tb/tb_complex_accumulator.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_accumulator.sv
// Streaming complex accumulator: sums a frame of complex products into one result with a sticky
// error flag. Build option CACC_SAT_EN selects saturating (vs. wrapping) reduction to W bits.
module complex_accumulator #(
  parameter int QI    = 3,
  parameter int QF    = 3,
  parameter int GUARD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [QI+QF-1:0]      in_Re,
  input  logic [QI+QF-1:0]      in_Im,
  input  logic                  in_err,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QI+QF-1:0]      out_Re,
  output logic [QI+QF-1:0]      out_Im,
  output logic                  out_sat,
  output logic                  out_err,
  output logic [GUARD:0]        out_count
);

  localparam int W       = QI + QF;
  localparam int ACC_W   = W + GUARD;
  localparam int MAX_LEN = 2 ** GUARD;
  localparam logic [GUARD:0] MaxCount = (GUARD + 1)'(MAX_LEN);

  typedef enum logic [0:0] {StAcc, StOut} state_e;

  state_e                    state_q;
  logic signed [ACC_W-1:0]   acc_re_q, acc_im_q;
  logic [GUARD:0]            count_q;
  logic                      err_q;

  logic                      out_valid_q, out_sat_q, out_err_q;
  logic [W-1:0]              out_re_q, out_im_q;
  logic [GUARD:0]            out_count_q;

  logic signed [ACC_W-1:0]   sum_re, sum_im;
  logic [GUARD:0]            count_inc;
  logic                      accept, forced_end, frame_end;
  logic [W-1:0]              red_re, red_im;
  logic                      sat_re, sat_im;

  assign in_ready  = (state_q == StAcc);
  assign accept    = in_valid & in_ready;
  assign count_inc = count_q + (GUARD + 1)'(1);
  // A frame that fills the accumulator without in_last is cut short and flagged.
  assign forced_end = (count_inc == MaxCount) & ~in_last;
  assign frame_end  = in_last | (count_inc == MaxCount);

  always_comb begin
    sum_re = acc_re_q + {{GUARD{in_Re[W-1]}}, in_Re};
    sum_im = acc_im_q + {{GUARD{in_Im[W-1]}}, in_Im};
  end

`ifdef CACC_SAT_EN
  localparam logic signed [ACC_W-1:0] SatHi = ACC_W'((2 ** (W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SatLo = -SatHi - ACC_W'(1);

  always_comb begin
    red_re = sum_re[W-1:0];
    red_im = sum_im[W-1:0];
    sat_re = 1'b0;
    sat_im = 1'b0;
    if (sum_re > SatHi) begin
      red_re = SatHi[W-1:0];
      sat_re = 1'b1;
    end else if (sum_re < SatLo) begin
      red_re = SatLo[W-1:0];
      sat_re = 1'b1;
    end
    if (sum_im > SatHi) begin
      red_im = SatHi[W-1:0];
      sat_im = 1'b1;
    end else if (sum_im < SatLo) begin
      red_im = SatLo[W-1:0];
      sat_im = 1'b1;
    end
  end
`else
  // Two's-complement wrap: keep the low W bits, never report saturation.
  always_comb begin
    red_re = sum_re[W-1:0];
    red_im = sum_im[W-1:0];
    sat_re = 1'b0;
    sat_im = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StAcc;
      acc_re_q    <= '0;
      acc_im_q    <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_sat_q   <= 1'b0;
      out_err_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      unique case (state_q)
        StAcc: begin
          if (accept) begin
            if (frame_end) begin
              out_re_q    <= red_re;
              out_im_q    <= red_im;
              out_sat_q   <= sat_re | sat_im;
              out_err_q   <= err_q | in_err | forced_end;
              out_count_q <= count_inc;
              out_valid_q <= 1'b1;
              acc_re_q    <= '0;
              acc_im_q    <= '0;
              count_q     <= '0;
              err_q       <= 1'b0;
              state_q     <= StOut;
            end else begin
              acc_re_q <= sum_re;
              acc_im_q <= sum_im;
              count_q  <= count_inc;
              err_q    <= err_q | in_err;
            end
          end
        end
        StOut: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StAcc;
          end
        end
        default: state_q <= StAcc;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_Re    = out_re_q;
  assign out_Im    = out_im_q;
  assign out_sat   = out_sat_q;
  assign out_err   = out_err_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_complex_accumulator.sv
// Directed bench for complex_accumulator with an expected-result scoreboard queue.
// Expectations follow the build: CACC_SAT_EN selects saturating results.
module tb_complex_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_Re, in_Im;
  logic       in_err, in_last;
  logic       out_valid, out_ready;
  logic [5:0] out_Re, out_Im;
  logic       out_sat, out_err;
  logic [4:0] out_count;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int re;
    int im;
    int sat;
    int err;
    int cnt;
  } exp_t;
  exp_t sb[$];

  int m_re = 0, m_im = 0, m_cnt = 0, m_err = 0;

  complex_accumulator #(.QI(3), .QF(3), .GUARD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_Re     (in_Re),
    .in_Im     (in_Im),
    .in_err    (in_err),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_Re    (out_Re),
    .out_Im    (out_Im),
    .out_sat   (out_sat),
    .out_err   (out_err),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int reduce(input int s, output int sat);
    int v;
    sat = 0;
`ifdef CACC_SAT_EN
    if (s > 31) begin
      sat = 1;
      return 31;
    end
    if (s < -32) begin
      sat = 1;
      return -32;
    end
    return s;
`else
    v = s & 63;
    if (v > 31) v = v - 64;
    return v;
`endif
  endfunction

  task automatic model_clear();
    m_re = 0;
    m_im = 0;
    m_cnt = 0;
    m_err = 0;
  endtask

  task automatic send(input int re, input int im, input bit err, input bit last);
    int n = 0;
    exp_t e;
    int sr, si;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send_ready_timeout", in_ready, 1);
    in_valid = 1'b1;
    in_Re    = 6'(re);
    in_Im    = 6'(im);
    in_err   = err;
    in_last  = last;
    m_re += re;
    m_im += im;
    m_cnt++;
    if (err) m_err = 1;
    if (last || m_cnt == 16) begin
      e.re  = reduce(m_re, sr);
      e.im  = reduce(m_im, si);
      e.sat = sr | si;
      e.err = m_err | ((m_cnt == 16 && !last) ? 1 : 0);
      e.cnt = m_cnt;
      sb.push_back(e);
      model_clear();
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_Re    = 'x;
    in_Im    = 'x;
    in_err   = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic recv(input string tag);
    int n = 0;
    exp_t e;
    while (out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, out_valid, 1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_re"}, $signed(out_Re), e.re);
    check({tag, "_im"}, $signed(out_Im), e.im);
    check({tag, "_sat"}, out_sat, e.sat);
    check({tag, "_err"}, out_err, e.err);
    check({tag, "_count"}, out_count, e.cnt);
    check({tag, "_ready_in_out"}, in_ready, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_ready_back"}, in_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_re"}, out_Re, 0);
    check({tag, "_im"}, out_Im, 0);
    check({tag, "_count"}, out_count, 0);
    check({tag, "_sat"}, out_sat, 0);
    check({tag, "_err"}, out_err, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    logic [5:0] hold_re, hold_im;
    logic [4:0] hold_cnt;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_Re     = '0;
    in_Im     = '0;
    in_err    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // Basic three-sample frame with a one-cycle latency check.
    send(8, -4, 0, 0);
    send(8, -4, 0, 0);
    check("lat_not_early", out_valid, 0);
    send(8, -4, 0, 1);
    check("lat_one_cycle", out_valid, 1);
    recv("basic");

    // Sums outside the 6-bit range: saturate or wrap depending on build.
    for (int i = 0; i < 5; i++) send(10, -10, 0, (i == 4));
    recv("sat");

    // Back-pressure: outputs hold and input pulses are ignored.
    send(3, -7, 0, 0);
    send(-2, 4, 0, 1);
    hold_re  = out_Re;
    hold_im  = out_Im;
    hold_cnt = out_count;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_Re    = 6'(i + 1);
      in_Im    = 6'(i + 1);
      in_last  = 1'b1;
      in_err   = 1'b1;
      @(negedge clk);
      check("bp_valid_held", out_valid, 1);
      check("bp_re_held", out_Re, hold_re);
      check("bp_im_held", out_Im, hold_im);
      check("bp_count_held", out_count, hold_cnt);
      check("bp_in_ready_low", in_ready, 0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_err   = 1'b0;
    recv("bp");

    // Forced end after MAX_LEN samples without in_last.
    for (int i = 0; i < 16; i++) send(1, 1, 0, 0);
    recv("forced");

    // Error on the first sample, then a clean frame must not inherit it.
    send(2, 3, 1, 0);
    send(1, 1, 0, 1);
    recv("err_frame");
    send(4, -2, 0, 0);
    send(-1, 1, 0, 1);
    recv("clean_frame");

    // Error on the last sample only.
    send(5, 5, 0, 1);
    recv("single");
    send(-3, 2, 0, 0);
    send(-3, 2, 1, 1);
    recv("err_last");

    // Reset mid-frame discards the partial frame.
    send(5, 5, 0, 0);
    send(5, 5, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    check_reset_outputs("mid_reset");
    send(1, 1, 0, 1);
    recv("after_reset");

    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
